board_write_controller: RTL and testbench

//  Owns the 81-cell game board register and sequences every cell write into it. Loads the

---
 rtl/sudoku_pkg.sv | 33 +++
 rtl/peer_addr_gen.sv | 35 +++
 rtl/board_write_controller.sv | 197 +++++++++++++++++++
 tb/tb_board_write_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sudoku_pkg
// Purpose : Board geometry, FSM state and write-status encodings shared by the
//           board write controller and its peer address generator.
// Revision: 1.0 - initial release
// ============================================================================
package sudoku_pkg;
  localparam int BOX     = 3;
  localparam int N       = BOX * BOX;
  localparam int CELLS   = N * N;
  localparam int CELL_W  = 4;
  localparam int BOARD_W = CELLS * CELL_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WR_OK       = 2'b00,
    WR_CONFLICT = 2'b01,
    WR_LOCKED   = 2'b10,
    WR_RANGE    = 2'b11
  } wr_status_t;

  function automatic logic [6:0] cell_idx(input logic [3:0] i, input logic [3:0] j);
    return (7'(i) * 7'd9) + 7'(j);
  endfunction
endpackage
`default_nettype wire

// File: rtl/peer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : peer_addr_gen
// Purpose : Maps target (row, col) and scan step k to the row, column and box
//           peer cell indices, flagging any peer that is the target itself.
// Revision: 1.0 - initial release
// ============================================================================
module peer_addr_gen
  import sudoku_pkg::*;
(
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  input  logic [3:0] i_k,
  output logic [6:0] o_row_idx,
  output logic [6:0] o_col_idx,
  output logic [6:0] o_box_idx,
  output logic       o_row_self,
  output logic       o_col_self,
  output logic       o_box_self
);
  logic [3:0] w_box_r;
  logic [3:0] w_box_c;

  // Box origin is the target's row/col rounded down to a multiple of 3.
  assign w_box_r = (i_row / 4'd3) * 4'd3 + i_k / 4'd3;
  assign w_box_c = (i_col / 4'd3) * 4'd3 + i_k % 4'd3;

  assign o_row_idx  = cell_idx(i_row, i_k);
  assign o_col_idx  = cell_idx(i_k, i_col);
  assign o_box_idx  = cell_idx(w_box_r, w_box_c);
  assign o_row_self = (i_k == i_col);
  assign o_col_self = (i_k == i_row);
  assign o_box_self = (w_box_r == i_row) && (w_box_c == i_col);
endmodule
`default_nettype wire

// File: rtl/board_write_controller.sv
`default_nettype none
// ============================================================================
// Module  : board_write_controller
// Purpose : Owns the 81-cell board and lock map, validates and conflict-scans
//           each cell write, commits only clean writes.
//           Option macro SOLVED_DETECT_EN: filled-cell counter and solved flag.
// Revision: 1.0 - initial release
// ============================================================================
module board_write_controller
  import sudoku_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BOARD_W-1:0] selected_map,
  input  logic [CELLS-1:0]   selected_visibility,
  input  logic               wr_req,
  input  logic [3:0]         wr_i,
  input  logic [3:0]         wr_j,
  input  logic [3:0]         wr_val,
  output logic               wr_ack,
  output logic [1:0]         wr_status,
  output logic               busy,
  output logic [BOARD_W-1:0] board,
  output logic [6:0]         filled_count,
  output logic               solved
);
`ifdef SOLVED_DETECT_EN
  localparam state_t c_after_load = ST_LOAD;
`else
  localparam state_t c_after_load = ST_IDLE;
`endif

  state_t             r_state;
  logic [3:0]         r_i, r_j, r_val, r_k;
  logic               r_hit, r_ack;
  wr_status_t         r_status;
  logic [BOARD_W-1:0] r_board;
  logic [CELLS-1:0]   r_lock;

  logic [6:0] w_row_idx, w_col_idx, w_box_idx, w_req_idx, w_tgt_idx;
  logic       w_row_self, w_col_self, w_box_self;
  logic       w_peer_hit, w_conflict, w_req_range, w_req_locked;

  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b,
                                                input logic [6:0] idx);
    return b[CELL_W*idx +: CELL_W];
  endfunction

  peer_addr_gen u_peer (
    .i_row      (r_i),
    .i_col      (r_j),
    .i_k        (r_k),
    .o_row_idx  (w_row_idx),
    .o_col_idx  (w_col_idx),
    .o_box_idx  (w_box_idx),
    .o_row_self (w_row_self),
    .o_col_self (w_col_self),
    .o_box_self (w_box_self)
  );

  assign w_req_idx    = cell_idx(wr_i, wr_j);
  assign w_tgt_idx    = cell_idx(r_i, r_j);
  assign w_req_range  = (wr_i > 4'd8) || (wr_j > 4'd8) || (wr_val > 4'd9);
  assign w_req_locked = r_lock[w_req_idx];
  // Self-flags keep the target's current contents out of the duplicate check.
  assign w_peer_hit   = (!w_row_self && cell_at(r_board, w_row_idx) == r_val) ||
                        (!w_col_self && cell_at(r_board, w_col_idx) == r_val) ||
                        (!w_box_self && cell_at(r_board, w_box_idx) == r_val);
  assign w_conflict   = r_hit || w_peer_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_val    <= '0;
      r_k      <= '0;
      r_hit    <= 1'b0;
      r_ack    <= 1'b0;
      r_status <= WR_OK;
      r_board  <= '0;
      r_lock   <= '0;
    end else begin
      r_ack <= 1'b0;
      if (load) begin
        r_board <= selected_map;
        r_lock  <= selected_visibility;
        r_k     <= '0;
        r_state <= c_after_load;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (wr_req) begin
              r_i   <= wr_i;
              r_j   <= wr_j;
              r_val <= wr_val;
              r_k   <= '0;
              r_hit <= 1'b0;
              if (w_req_range) begin
                r_status <= WR_RANGE;
                r_ack    <= 1'b1;
                r_state  <= ST_RESP;
              end else if (w_req_locked) begin
                r_status <= WR_LOCKED;
                r_ack    <= 1'b1;
                r_state  <= ST_RESP;
              end else if (wr_val == 4'd0) begin
                r_board[CELL_W*w_req_idx +: CELL_W] <= '0;
                r_status <= WR_OK;
                r_ack    <= 1'b1;
                r_state  <= ST_RESP;
              end else begin
                r_state <= ST_SCAN;
              end
            end
          end
          ST_SCAN: begin
            r_hit <= w_conflict;
            r_k   <= r_k + 4'd1;
            if (r_k == 4'(N-1)) begin
              r_ack   <= 1'b1;
              r_state <= ST_RESP;
              if (w_conflict) begin
                r_status <= WR_CONFLICT;
              end else begin
                r_status <= WR_OK;
                r_board[CELL_W*w_tgt_idx +: CELL_W] <= r_val;
              end
            end
          end
          ST_RESP: r_state <= ST_IDLE;
          ST_LOAD: begin
            r_k <= r_k + 4'd1;
            if (r_k == 4'(N-1)) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_ack    = r_ack;
  assign wr_status = r_status;
  assign busy      = (r_state != ST_IDLE);
  assign board     = r_board;

`ifdef SOLVED_DETECT_EN
  logic [6:0] r_fill;
  logic       r_solved;
  logic [6:0] w_fill_next;
  logic       w_clear, w_commit;

  function automatic logic [3:0] row_filled(input logic [BOARD_W-1:0] b,
                                            input logic [3:0] row);
    logic [3:0] cnt;
    cnt = '0;
    for (int c = 0; c < N; c++)
      if (cell_at(b, cell_idx(row, 4'(c))) != '0) cnt = cnt + 4'd1;
    return cnt;
  endfunction

  assign w_clear  = (r_state == ST_IDLE) && wr_req && !load && !w_req_range &&
                    !w_req_locked && (wr_val == 4'd0);
  assign w_commit = (r_state == ST_SCAN) && (r_k == 4'(N-1)) && !load && !w_conflict;

  // Full recount after a load; afterwards only the delta of each committed write.
  always_comb begin
    w_fill_next = r_fill;
    if (load)
      w_fill_next = '0;
    else if (r_state == ST_LOAD)
      w_fill_next = r_fill + {3'b000, row_filled(r_board, r_k)};
    else if (w_clear && cell_at(r_board, w_req_idx) != '0)
      w_fill_next = r_fill - 7'd1;
    else if (w_commit && cell_at(r_board, w_tgt_idx) == '0)
      w_fill_next = r_fill + 7'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill   <= '0;
      r_solved <= 1'b0;
    end else begin
      r_fill   <= w_fill_next;
      r_solved <= (w_fill_next == 7'(CELLS));
    end
  end

  assign filled_count = r_fill;
  assign solved       = r_solved;
`else
  assign filled_count = '0;
  assign solved       = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_board_write_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_board_write_controller
// Purpose : Self-checking bench for board_write_controller against a plain
//           array model of the board and the sudoku write rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_board_write_controller;
`ifdef SOLVED_DETECT_EN
  localparam bit SDE = 1'b1;
`else
  localparam bit SDE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, load, wr_req;
  logic [323:0] selected_map;
  logic [80:0]  selected_visibility;
  logic [3:0]   wr_i, wr_j, wr_val;
  logic         wr_ack, busy, solved;
  logic [1:0]   wr_status;
  logic [323:0] board;
  logic [6:0]   filled_count;

  board_write_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .load                (load),
    .selected_map        (selected_map),
    .selected_visibility (selected_visibility),
    .wr_req              (wr_req),
    .wr_i                (wr_i),
    .wr_j                (wr_j),
    .wr_val              (wr_val),
    .wr_ack              (wr_ack),
    .wr_status           (wr_status),
    .busy                (busy),
    .board               (board),
    .filled_count        (filled_count),
    .solved              (solved)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int mb[9][9];
  bit ml[9][9];

  typedef struct {int op; int i; int j; int v; int lat; logic [1:0] st;} step_t;

  function automatic logic [323:0] model_board();
    logic [323:0] b;
    b = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) b[4*(r*9+c) +: 4] = 4'(mb[r][c]);
    return b;
  endfunction

  function automatic int model_fill();
    int cnt;
    cnt = 0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) if (mb[r][c] != 0) cnt++;
    return SDE ? cnt : 0;
  endfunction

  function automatic void model_load(input logic [323:0] m, input logic [80:0] v);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        mb[r][c] = int'(m[4*(r*9+c) +: 4]);
        ml[r][c] = v[r*9+c];
      end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin mb[r][c] = 0; ml[r][c] = 1'b0; end
  endfunction

  function automatic bit in_range(input int i, input int j, input int v);
    return (i <= 8) && (j <= 8) && (v <= 9);
  endfunction

  function automatic logic [1:0] model_status(input int i, input int j, input int v);
    if (!in_range(i, j, v)) return 2'b11;
    if (ml[i][j]) return 2'b10;
    if (v == 0) return 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (k != j && mb[i][k] == v) return 2'b01;
      if (k != i && mb[k][j] == v) return 2'b01;
    end
    for (int r = (i/3)*3; r < (i/3)*3 + 3; r++)
      for (int c = (j/3)*3; c < (j/3)*3 + 3; c++)
        if ((r != i || c != j) && mb[r][c] == v) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int model_latency(input int i, input int j, input int v);
    if (!in_range(i, j, v) || ml[i][j] || v == 0) return 1;
    return 10;
  endfunction

  task automatic wait_idle();
    @(negedge clk);
    for (int t = 0; t < 40 && busy !== 1'b0; t++) @(negedge clk);
  endtask

  // Drives one request and reports the cycle on which wr_ack was seen (-1: none).
  task automatic issue_write(input int i, input int j, input int v,
                             output int lat, output logic [1:0] st);
    wait_idle();
    wr_i = 4'(i); wr_j = 4'(j); wr_val = 4'(v); wr_req = 1'b1;
    lat = -1; st = 2'b00;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) begin lat = n; st = wr_status; break; end
    end
    wr_req = 1'b0;
  endtask

  task automatic do_load(input logic [323:0] m, input logic [80:0] v, output int bc);
    wait_idle();
    selected_map = m; selected_visibility = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    for (int t = 0; t < 40 && busy === 1'b1; t++) begin bc++; @(negedge clk); end
    model_load(m, v);
  endtask

  task automatic rand_map(output logic [323:0] m, output logic [80:0] v);
    m = '0; v = '0;
    for (int c = 0; c < 81; c++)
      if ($urandom_range(99) < 30) begin
        m[4*c +: 4] = 4'($urandom_range(9, 1));
        v[c] = 1'($urandom_range(1));
      end
  endtask

  task automatic map_by_id(input int id, output logic [323:0] m, output logic [80:0] v);
    m = '0; v = '0;
    case (id)
      1: begin m[4*36 +: 4] = 4'd5; v[36] = 1'b1; end
      2: begin m[4*30 +: 4] = 4'd5; v[30] = 1'b1; end
      3: begin m[3:0] = 4'd3; v[0] = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; wr_req = 1'b0;
    wr_i = '0; wr_j = '0; wr_val = '0;
    selected_map = '0; selected_visibility = '0;
    #1 reset = 1'b0;
    #2;
    n_checks++; if (wr_ack !== 1'b0) $display("FAIL reset wr_ack: got %b want 0", wr_ack); else n_pass++;
    n_checks++; if (wr_status !== 2'b00) $display("FAIL reset wr_status: got %b want 00", wr_status); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (board !== '0) $display("FAIL reset board: got %h want 0", board); else n_pass++;
    n_checks++; if (filled_count !== 7'd0) $display("FAIL reset filled_count: got %0d want 0", filled_count); else n_pass++;
    n_checks++; if (solved !== 1'b0) $display("FAIL reset solved: got %b want 0", solved); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_directed();
    step_t        steps[$];
    logic [323:0] m;
    logic [80:0]  v;
    int           bc, lat;
    logic [1:0]   st;
    steps.push_back('{1, 0, 0, 0, 0, 2'b00});
    steps.push_back('{0, 4, 4, 5, 10, 2'b00});
    steps.push_back('{1, 1, 0, 0, 0, 2'b00});
    steps.push_back('{0, 4, 8, 5, 10, 2'b01});
    steps.push_back('{1, 2, 0, 0, 0, 2'b00});
    steps.push_back('{0, 5, 5, 5, 10, 2'b01});
    steps.push_back('{0, 0, 0, 5, 10, 2'b00});
    steps.push_back('{1, 3, 0, 0, 0, 2'b00});
    steps.push_back('{0, 0, 0, 4, 1, 2'b10});
    steps.push_back('{0, 9, 0, 1, 1, 2'b11});
    steps.push_back('{0, 1, 1, 10, 1, 2'b11});
    steps.push_back('{0, 2, 2, 7, 10, 2'b00});
    steps.push_back('{0, 2, 2, 0, 1, 2'b00});
    steps.push_back('{0, 2, 2, 7, 10, 2'b00});
    steps.push_back('{0, 2, 2, 7, 10, 2'b00});
    steps.push_back('{0, 0, 5, 3, 10, 2'b01});
    foreach (steps[n]) begin
      if (steps[n].op == 1) begin
        map_by_id(steps[n].i, m, v);
        do_load(m, v, bc);
        n_checks++; if (bc !== (SDE ? 9 : 0)) $display("FAIL dir%0d load busy cycles: got %0d want %0d", n, bc, SDE ? 9 : 0); else n_pass++;
        n_checks++; if (board !== m) $display("FAIL dir%0d load board: got %h want %h", n, board, m); else n_pass++;
      end else begin
        issue_write(steps[n].i, steps[n].j, steps[n].v, lat, st);
        if (st == 2'b00 && lat > 0) mb[steps[n].i][steps[n].j] = steps[n].v;
        if (steps[n].st == 2'b00) mb[steps[n].i][steps[n].j] = steps[n].v;
        n_checks++; if (lat !== steps[n].lat) $display("FAIL dir%0d latency: got %0d want %0d", n, lat, steps[n].lat); else n_pass++;
        n_checks++; if (st !== steps[n].st) $display("FAIL dir%0d status: got %b want %b", n, st, steps[n].st); else n_pass++;
        n_checks++; if (board !== model_board()) $display("FAIL dir%0d board: got %h want %h", n, board, model_board()); else n_pass++;
        n_checks++; if (filled_count !== 7'(model_fill())) $display("FAIL dir%0d filled_count: got %0d want %0d", n, filled_count, model_fill()); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [323:0] m;
    logic [80:0]  v;
    int           bc, lat, i, j, val, exp_lat;
    logic [1:0]   st, exp_st;
    rand_map(m, v);
    do_load(m, v, bc);
    n_checks++; if (filled_count !== 7'(model_fill())) $display("FAIL rand load filled_count: got %0d want %0d", filled_count, model_fill()); else n_pass++;
    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(9); j = $urandom_range(9); val = $urandom_range(10);
      exp_st  = model_status(i, j, val);
      exp_lat = model_latency(i, j, val);
      if (exp_st == 2'b00) mb[i][j] = val;
      issue_write(i, j, val, lat, st);
      n_checks++; if (lat !== exp_lat) $display("FAIL rand%0d (%0d,%0d)=%0d latency: got %0d want %0d", n, i, j, val, lat, exp_lat); else n_pass++;
      n_checks++; if (st !== exp_st) $display("FAIL rand%0d (%0d,%0d)=%0d status: got %b want %b", n, i, j, val, st, exp_st); else n_pass++;
      n_checks++; if (board !== model_board()) $display("FAIL rand%0d board: got %h want %h", n, board, model_board()); else n_pass++;
      n_checks++; if (filled_count !== 7'(model_fill())) $display("FAIL rand%0d filled_count: got %0d want %0d", n, filled_count, model_fill()); else n_pass++;
    end
  endtask

  task automatic test_load_abort();
    logic [323:0] m, m2;
    logic [80:0]  v, v2;
    int           bc, ti, tj;
    bit           ack_seen;
    rand_map(m, v);
    do_load(m, v, bc);
    ti = 0; tj = 0;
    for (int t = 0; t < 81; t++) if (!ml[t/9][t%9]) begin ti = t / 9; tj = t % 9; break; end
    rand_map(m2, v2);
    wait_idle();
    wr_i = 4'(ti); wr_j = 4'(tj); wr_val = 4'($urandom_range(9, 1)); wr_req = 1'b1;
    ack_seen = 1'b0;
    for (int n = 0; n < 4; n++) begin @(negedge clk); ack_seen |= (wr_ack === 1'b1); end
    selected_map = m2; selected_visibility = v2; load = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    load = 1'b0;
    for (int n = 0; n < 20; n++) begin ack_seen |= (wr_ack === 1'b1); @(negedge clk); end
    model_load(m2, v2);
    n_checks++; if (ack_seen !== 1'b0) $display("FAIL abort wr_ack seen: got %b want 0", ack_seen); else n_pass++;
    n_checks++; if (board !== m2) $display("FAIL abort board: got %h want %h", board, m2); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (filled_count !== 7'(model_fill())) $display("FAIL abort filled_count: got %0d want %0d", filled_count, model_fill()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [323:0] m;
    logic [80:0]  v;
    int           bc;
    m = '0; v = '0;
    m[4*10 +: 4] = 4'd6; m[4*70 +: 4] = 4'd2; v[70] = 1'b1;
    do_load(m, v, bc);
    wait_idle();
    wr_i = 4'd4; wr_j = 4'd4; wr_val = 4'd8; wr_req = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (wr_ack !== 1'b0) $display("FAIL midreset wr_ack: got %b want 0", wr_ack); else n_pass++;
    n_checks++; if (wr_status !== 2'b00) $display("FAIL midreset wr_status: got %b want 00", wr_status); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (board !== '0) $display("FAIL midreset board: got %h want 0", board); else n_pass++;
    n_checks++; if (filled_count !== 7'd0) $display("FAIL midreset filled_count: got %0d want 0", filled_count); else n_pass++;
    n_checks++; if (solved !== 1'b0) $display("FAIL midreset solved: got %b want 0", solved); else n_pass++;
    wr_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

`ifdef SOLVED_DETECT_EN
  task automatic test_solved();
    logic [323:0] m;
    logic [80:0]  v;
    int           bc, lat, last;
    logic [1:0]   st;
    m = '0; v = '1;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) m[4*(r*9+c) +: 4] = 4'(((r*3 + r/3 + c) % 9) + 1);
    last = int'(m[4*80 +: 4]);
    m[4*80 +: 4] = 4'd0; v[80] = 1'b0;
    do_load(m, v, bc);
    n_checks++; if (bc !== 9) $display("FAIL solved load busy cycles: got %0d want 9", bc); else n_pass++;
    n_checks++; if (filled_count !== 7'd80) $display("FAIL solved load count: got %0d want 80", filled_count); else n_pass++;
    n_checks++; if (solved !== 1'b0) $display("FAIL solved after load: got %b want 0", solved); else n_pass++;
    issue_write(8, 8, last, lat, st);
    n_checks++; if (st !== 2'b00 || lat !== 10) $display("FAIL solved last write: got st %b lat %0d want 00/10", st, lat); else n_pass++;
    n_checks++; if (filled_count !== 7'd81) $display("FAIL solved full count: got %0d want 81", filled_count); else n_pass++;
    n_checks++; if (solved !== 1'b1) $display("FAIL solved flag: got %b want 1", solved); else n_pass++;
    issue_write(8, 8, 0, lat, st);
    n_checks++; if (st !== 2'b00 || lat !== 1) $display("FAIL solved clear: got st %b lat %0d want 00/1", st, lat); else n_pass++;
    n_checks++; if (filled_count !== 7'd80) $display("FAIL solved clear count: got %0d want 80", filled_count); else n_pass++;
    n_checks++; if (solved !== 1'b0) $display("FAIL solved after clear: got %b want 0", solved); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_load_abort();
    test_reset_mid();
    test_random();
`ifdef SOLVED_DETECT_EN
    test_solved();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
